// File: rtl/cmac_accum.sv
// Streaming complex multiply-accumulate: 4-stage pipeline, per-frame accumulation, valid/ready result.
// Optional CMAC_SAT_EN: saturating accumulator with sticky overflow flag (default: wrap-around).
module cmac_accum #(
    parameter int DW = 32,
    parameter int AW = 2*DW+8,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] A,
    input  logic signed [DW-1:0] ja,
    input  logic signed [DW-1:0] B,
    input  logic signed [DW-1:0] jb,
    input  logic                 conj,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic signed [AW-1:0] REAL,
    output logic signed [AW-1:0] IMAGINARY,
    output logic [CW-1:0]        out_count,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int PW = 2*DW;
    localparam int SW = PW+1;

    logic                 stall;
    logic [3:1]           vld_pipe_q;
    logic signed [DW-1:0] s1_a_q, s1_ja_q, s1_b_q, s1_jb_q;
    logic                 s1_cj_q, s1_last_q;
    logic signed [PW-1:0] s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
    logic                 s2_cj_q, s2_last_q;
    logic signed [SW-1:0] s3_re_d, s3_im_d, s3_re_q, s3_im_q;
    logic                 s3_last_q;

    logic signed [AW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic signed [AW-1:0] sum_re, sum_im, term_re, term_im;
    logic                 ovf_re, ovf_im;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                 ovf_q, ovf_d;
    logic signed [AW-1:0] real_q, imag_q, real_d, imag_d;
    logic [CW-1:0]        ocnt_q, ocnt_d;
    logic                 oovf_q, oovf_d, ovld_q, ovld_d;

    // A result that nobody has taken freezes the whole pipeline, so nothing is dropped.
    assign stall     = ovld_q && !out_ready;
    assign in_ready  = !stall;
    assign REAL      = real_q;
    assign IMAGINARY = imag_q;
    assign out_count = ocnt_q;
    assign out_ovf   = oovf_q;
    assign out_valid = ovld_q;

    always_comb begin
        s3_re_d = SW'(s2_rr_q) - SW'(s2_ii_q);
        s3_im_d = SW'(s2_ri_q) + SW'(s2_ir_q);
        if (s2_cj_q) begin
            s3_re_d = SW'(s2_rr_q) + SW'(s2_ii_q);
            s3_im_d = SW'(s2_ir_q) - SW'(s2_ri_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            s1_a_q <= '0; s1_ja_q <= '0; s1_b_q <= '0; s1_jb_q <= '0;
            s1_cj_q <= 1'b0; s1_last_q <= 1'b0;
            s2_rr_q <= '0; s2_ii_q <= '0; s2_ri_q <= '0; s2_ir_q <= '0;
            s2_cj_q <= 1'b0; s2_last_q <= 1'b0;
            s3_re_q <= '0; s3_im_q <= '0; s3_last_q <= 1'b0;
        end else if (!stall) begin
            vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
            if (in_valid) begin
                s1_a_q <= A; s1_ja_q <= ja; s1_b_q <= B; s1_jb_q <= jb;
                s1_cj_q <= conj; s1_last_q <= in_last;
            end
            if (vld_pipe_q[1]) begin
                s2_rr_q <= PW'(s1_a_q)  * PW'(s1_b_q);
                s2_ii_q <= PW'(s1_ja_q) * PW'(s1_jb_q);
                s2_ri_q <= PW'(s1_a_q)  * PW'(s1_jb_q);
                s2_ir_q <= PW'(s1_ja_q) * PW'(s1_b_q);
                s2_cj_q <= s1_cj_q; s2_last_q <= s1_last_q;
            end
            if (vld_pipe_q[2]) begin
                s3_re_q <= s3_re_d; s3_im_q <= s3_im_d; s3_last_q <= s2_last_q;
            end
        end
    end

`ifdef CMAC_SAT_EN
    // Bit AW of the result flags overflow; the low AW bits are the clamped sum.
    function automatic logic [AW:0] sat_add(input logic signed [AW-1:0] x, input logic signed [AW-1:0] y);
        logic [AW:0] s;
        s = {x[AW-1], x} + {y[AW-1], y};
        if (s[AW] != s[AW-1]) sat_add = {1'b1, s[AW], {(AW-1){~s[AW]}}};
        else                  sat_add = {1'b0, s[AW-1:0]};
    endfunction
`endif

    always_comb begin
        term_re = AW'(s3_re_q);
        term_im = AW'(s3_im_q);
`ifdef CMAC_SAT_EN
        {ovf_re, sum_re} = sat_add(acc_re_q, term_re);
        {ovf_im, sum_im} = sat_add(acc_im_q, term_im);
`else
        ovf_re = 1'b0;
        ovf_im = 1'b0;
        sum_re = acc_re_q + term_re;
        sum_im = acc_im_q + term_im;
`endif
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        real_d   = real_q;
        imag_d   = imag_q;
        ocnt_d   = ocnt_q;
        oovf_d   = oovf_q;
        ovld_d   = ovld_q && !out_ready;
        if (!stall && vld_pipe_q[3]) begin
            if (s3_last_q) begin
                real_d   = sum_re;
                imag_d   = sum_im;
                ocnt_d   = cnt_inc;
                oovf_d   = ovf_q | ovf_re | ovf_im;
                ovld_d   = 1'b1;
                acc_re_d = '0;
                acc_im_d = '0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
            end else begin
                acc_re_d = sum_re;
                acc_im_d = sum_im;
                cnt_d    = cnt_inc;
                ovf_d    = ovf_q | ovf_re | ovf_im;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_re_q <= '0; acc_im_q <= '0; cnt_q <= '0; ovf_q <= 1'b0;
            real_q <= '0; imag_q <= '0; ocnt_q <= '0; oovf_q <= 1'b0; ovld_q <= 1'b0;
        end else begin
            acc_re_q <= acc_re_d; acc_im_q <= acc_im_d; cnt_q <= cnt_d; ovf_q <= ovf_d;
            real_q <= real_d; imag_q <= imag_d; ocnt_q <= ocnt_d; oovf_q <= oovf_d; ovld_q <= ovld_d;
        end
    end
endmodule

// File: tb/tb_cmac_accum.sv
// Directed bench for cmac_accum (AW=66); expectations follow CMAC_SAT_EN when it is defined.
module tb_cmac_accum;
    localparam int DW = 32;
    localparam int AW = 66;
    localparam int CW = 16;

    logic                 clk, reset;
    logic signed [DW-1:0] A, ja, B, jb;
    logic                 conj, in_valid, in_last, in_ready, out_ovf, out_valid, out_ready;
    logic signed [AW-1:0] REAL, IMAGINARY;
    logic [CW-1:0]        out_count;
    int checks = 0;
    int errors = 0;

    cmac_accum #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .A(A), .ja(ja), .B(B), .jb(jb), .conj(conj),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .REAL(REAL), .IMAGINARY(IMAGINARY), .out_count(out_count),
        .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] aj,
                        input logic signed [DW-1:0] b, input logic signed [DW-1:0] bj,
                        input logic cj, input logic lst);
        int n;
        A = a; ja = aj; B = b; jb = bj; conj = cj; in_last = lst; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL %s_timeout: out_valid=%0b expected 1", nm, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; out_ready = 1'b1; idle();
        A = '0; ja = '0; B = '0; jb = '0; conj = 1'b0;
        #2;
        checks++; if (REAL !== '0) begin errors++; $display("FAIL rst_real: got %0d expected 0", REAL); end
        checks++; if (IMAGINARY !== '0) begin errors++; $display("FAIL rst_imag: got %0d expected 0", IMAGINARY); end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", out_count); end
        checks++; if (out_valid !== 1'b0 || out_ovf !== 1'b0) begin errors++; $display("FAIL rst_flags: got vld=%0b ovf=%0b expected 0 0", out_valid, out_ovf); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_single();
        send(3, 4, 5, -2, 1'b0, 1'b1); idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early%0d: got out_valid=%0b expected 0", i, out_valid); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_t3: got out_valid=%0b expected 1", out_valid); end
        checks++; if (REAL !== 66'sd23) begin errors++; $display("FAIL single_real: got %0d expected 23", REAL); end
        checks++; if (IMAGINARY !== 66'sd14) begin errors++; $display("FAIL single_imag: got %0d expected 14", IMAGINARY); end
        checks++; if (out_count !== 16'd1 || out_ovf !== 1'b0) begin errors++; $display("FAIL single_cnt: got %0d/%0b expected 1/0", out_count, out_ovf); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_clear: got out_valid=%0b expected 0", out_valid); end
    endtask

    task automatic test_conj();
        send(3, 4, 5, -2, 1'b1, 1'b1); idle();
        wait_valid("conj");
        checks++; if (REAL !== 66'sd7) begin errors++; $display("FAIL conj_real: got %0d expected 7", REAL); end
        checks++; if (IMAGINARY !== 66'sd26) begin errors++; $display("FAIL conj_imag: got %0d expected 26", IMAGINARY); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send(1, 1, 1, 1, 1'b0, i == 3);
        send(2, 0, 3, 1, 1'b0, 1'b1); idle();
        wait_valid("b2b_f1");
        checks++; if (REAL !== 66'sd0 || IMAGINARY !== 66'sd8) begin errors++; $display("FAIL b2b_f1_val: got %0d,%0d expected 0,8", REAL, IMAGINARY); end
        checks++; if (out_count !== 16'd4) begin errors++; $display("FAIL b2b_f1_cnt: got %0d expected 4", out_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_f2_vld: got %0b expected 1", out_valid); end
        checks++; if (REAL !== 66'sd6 || IMAGINARY !== 66'sd2) begin errors++; $display("FAIL b2b_f2_val: got %0d,%0d expected 6,2", REAL, IMAGINARY); end
        checks++; if (out_count !== 16'd1) begin errors++; $display("FAIL b2b_f2_cnt: got %0d expected 1", out_count); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(1, 0, 1, 0, 1'b0, 1'b0);
        send(2, 0, 3, 0, 1'b0, 1'b1);
        send(0, 1, 0, 1, 1'b0, 1'b0);
        send(1, 2, 3, 0, 1'b0, 1'b1);
        idle();
        wait_valid("stall_f1");
        // Offer a 1-sample frame while the output is blocked; it must wait.
        A = 5; ja = 0; B = 1; jb = 0; conj = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %0b expected 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || REAL !== 66'sd7 || IMAGINARY !== 66'sd0 || out_count !== 16'd2)
                begin errors++; $display("FAIL stall_hold%0d: got vld=%0b %0d,%0d cnt=%0d expected 1 7,0 cnt=2", i, out_valid, REAL, IMAGINARY, out_count); end
            @(negedge clk);
        end
        out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got in_ready=%0b expected 1", in_ready); end
        @(negedge clk); idle();
        wait_valid("stall_f2");
        checks++; if (REAL !== 66'sd2 || IMAGINARY !== 66'sd6 || out_count !== 16'd2)
            begin errors++; $display("FAIL stall_f2: got %0d,%0d cnt=%0d expected 2,6 cnt=2", REAL, IMAGINARY, out_count); end
        @(negedge clk);
        wait_valid("stall_f3");
        checks++; if (REAL !== 66'sd5 || IMAGINARY !== 66'sd0 || out_count !== 16'd1)
            begin errors++; $display("FAIL stall_f3: got %0d,%0d cnt=%0d expected 5,0 cnt=1", REAL, IMAGINARY, out_count); end
        @(negedge clk);
    endtask

    task automatic test_sat();
        logic signed [AW-1:0] exp_re;
        logic                 exp_ovf;
`ifdef CMAC_SAT_EN
        exp_re = {1'b0, {65{1'b1}}}; exp_ovf = 1'b1;
`else
        exp_re = {1'b1, 65'b0};      exp_ovf = 1'b0;
`endif
        for (int i = 0; i < 8; i++) send(32'sh8000_0000, 0, 32'sh8000_0000, 0, 1'b0, i == 7);
        idle();
        wait_valid("sat");
        checks++; if (REAL !== exp_re) begin errors++; $display("FAIL sat_real: got %0d expected %0d", REAL, exp_re); end
        checks++; if (out_ovf !== exp_ovf) begin errors++; $display("FAIL sat_ovf: got %0b expected %0b", out_ovf, exp_ovf); end
        checks++; if (IMAGINARY !== 66'sd0 || out_count !== 16'd8) begin errors++; $display("FAIL sat_misc: got %0d cnt=%0d expected 0 cnt=8", IMAGINARY, out_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send(3, 0, 3, 0, 1'b0, 1'b1); idle();
        wait_valid("pre_rst");
        checks++; if (REAL !== 66'sd9 || out_ovf !== 1'b0) begin errors++; $display("FAIL pre_rst: got %0d ovf=%0b expected 9 ovf=0", REAL, out_ovf); end
        @(negedge clk);
        send(1, 1, 1, 1, 1'b0, 1'b0);
        send(1, 1, 1, 1, 1'b0, 1'b0);
        idle();
        reset = 1'b0; #1;
        checks++; if (REAL !== '0 || IMAGINARY !== '0 || out_count !== '0 || out_valid !== 1'b0 || out_ovf !== 1'b0)
            begin errors++; $display("FAIL mid_rst: got %0d,%0d cnt=%0d vld=%0b ovf=%0b expected all 0", REAL, IMAGINARY, out_count, out_valid, out_ovf); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        send(2, 0, 2, 0, 1'b0, 1'b1); idle();
        wait_valid("post_rst");
        checks++; if (REAL !== 66'sd4 || IMAGINARY !== 66'sd0 || out_count !== 16'd1)
            begin errors++; $display("FAIL post_rst: got %0d,%0d cnt=%0d expected 4,0 cnt=1", REAL, IMAGINARY, out_count); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_conj();
        test_back_to_back();
        test_stall();
        test_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmac_accum.md
# cmac_accum

Parametrised streaming complex multiply-accumulate engine, the next-generation successor to the fixed 32-bit complex multiplier array. It accepts one complex sample pair per cycle, forms A·B or A·conj(B) through a 4-stage pipeline, and accumulates products over a frame delimited by `in_last`. Each frame yields one complex result with a sample count, behind a valid/ready output handshake. It sits between the sample front-end and correlation/dot-product consumers.

## Interface
- `DW`, 32: signed width of each input component.
- `AW`, 2*DW+8: signed accumulator/output width; must be ≥ 2*DW+1.
- `CW`, 16: frame sample-count width.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `A`, `ja`  in  DW  signed real/imag of operand 1.
- `B`, `jb`  in  DW  signed real/imag of operand 2.
- `conj`  in  1  per-sample: 1 = A·conj(B), 0 = A·B.
- `in_valid`  in  1  sample present.
- `in_last`  in  1  final sample of frame; qualified by `in_valid`.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `REAL`, `IMAGINARY`  out  AW  signed frame result.
- `out_count`  out  CW  samples in frame, saturating at 2^CW-1.
- `out_ovf`  out  1  accumulator saturated during frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.

## Operation
- Stage 1: register A, ja, B, jb, conj, last, valid on accept.
- Stage 2: four signed 2*DW products rr=A·B, ii=ja·jb, ri=A·jb, ir=ja·B.
- Stage 3 (2*DW+1 bits): conj=0 → re=rr−ii, im=ri+ir; conj=1 → re=rr+ii, im=ir−ri.
- Stage 4: sign-extend to AW, add to acc_re/acc_im; increment count. On a valid last: load REAL/IMAGINARY = acc + term, `out_count` = count+1, `out_ovf` = sticky flag; set `out_valid`; clear acc, count, flag in the same edge.
- Bubbles (stage valid=0) do not modify acc or count.
- Stall: `stall = out_valid && !out_ready`. When high, every pipeline stage and the accumulator hold, and `in_ready`=0; otherwise `in_ready`=1.
- `out_valid` clears on the edge where `out_ready`=1, unless a new last loads in that same edge, in which case it stays high with the new result.
- Frames are back-to-back capable; a 1-sample frame is `in_valid && in_last`.

## Timing
- Reset (asynchronous, low): all stage valids 0; acc, count, flag 0; `REAL`, `IMAGINARY`, `out_count` = 0; `out_ovf`=0; `out_valid`=0; `in_ready`=1 after release.
- Latency: last sample accepted at edge t → `out_valid` high after edge t+3 without stalls. Stall cycles add 1:1.
- Throughput: 1 sample/cycle when `out_ready` is held high.
- Reset mid-frame discards the partial frame and any pending result.
- Count saturates at 2^CW−1 and does not wrap.

## Configuration
- `CMAC_SAT_EN` defined: stage-4 add saturates each component to [−2^(AW−1), 2^(AW−1)−1] and sets the sticky overflow flag.
- Undefined: two's-complement wrap-around; `out_ovf` tied to 0.

## Test plan
- 1-sample frame, A=3, ja=4, B=5, jb=−2, conj=0, out_ready=1 → REAL=23, IMAGINARY=14, out_count=1, out_valid after edge t+3.
- Same inputs with conj=1 → REAL=7, IMAGINARY=26.
- 4-sample frame, all components=1, conj=0, contiguous → REAL=0, IMAGINARY=8, out_count=4; then an immediate 1-sample frame gives an independent result.
- Two back-to-back 2-sample frames with out_ready low for 5 cycles after the first out_valid → in_ready=0 during the stall, first result held stable, second delivered after the first handshake, no sample lost.
- AW=66, 8 samples of A=B=−2^31 (imag 0) → with CMAC_SAT_EN: REAL=2^65−1, out_ovf=1; without: REAL=−2^65, out_ovf=0.
- reset asserted after 2 samples of a frame → all outputs 0 immediately; next 1-sample frame (A=B=2, imag 0) → REAL=4, out_count=1.
